// File: rtl/multiplex_pkg.sv
// multiplex_pkg: scan states and the round-robin next-enabled-digit search for multiplex_n.
package multiplex_pkg;
  typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;
  function automatic int next_enabled(input logic [7:0] mask, input int idx, input int n);
    int r;
    r = -1;
    for (int i = n - 1; i >= 0; i--) if (mask[i] && i > idx) r = i;
    if (r < 0) for (int i = n - 1; i >= 0; i--) if (mask[i]) r = i;
    return (r < 0) ? idx : r;
  endfunction
endpackage

// File: rtl/mux_next_digit.sv
// mux_next_digit: combinational round-robin finder for the next enabled digit.
module mux_next_digit
  import multiplex_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int IW = $clog2(NUM_DIGITS)
) (
  input  logic [NUM_DIGITS-1:0] mask,
  input  logic [IW-1:0]         cur_idx,
  output logic [IW-1:0]         next_idx,
  output logic                  wrapped,
  output logic                  any_en
);
  assign next_idx = IW'(next_enabled(8'(mask), int'(cur_idx), NUM_DIGITS));
  assign wrapped  = next_idx <= cur_idx;
  assign any_en   = |mask;
endmodule

// File: rtl/multiplex_n.sv
// multiplex_n: seven-segment digit scanner with mask, blanking, frame tick; MULTIPLEX_N_DIM_EN adds brightness dimming.
module multiplex_n
  import multiplex_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DATA_W = 4,
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter logic [DATA_W-1:0] BLANK_CODE = '1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_DIGITS*DATA_W-1:0] digits,
  input  logic [NUM_DIGITS-1:0]        en_mask,
`ifdef MULTIPLEX_N_DIM_EN
  input  logic [3:0]                   bright,
`endif
  output logic [NUM_DIGITS-1:0]        d,
  output logic [DATA_W-1:0]            s,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                         frame_tick
);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam int BL = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] idx_n, cur_idx, nidx;
  logic [DATA_W-1:0] val, val_n;
  logic tick_n, wrapped, any_en, show_done, blank_done, to_blank, advance, lit;
  assign cur_idx = (state == IDLE) ? IW'(NUM_DIGITS - 1) : digit_idx;
  mux_next_digit #(.NUM_DIGITS(NUM_DIGITS), .IW(IW)) u_next (
    .mask(en_mask), .cur_idx(cur_idx), .next_idx(nidx), .wrapped(wrapped), .any_en(any_en)
  );
  assign show_done  = cnt == CW'(DWELL_CYCLES - 1);
  assign blank_done = cnt == CW'(BL);
  assign to_blank   = state == SHOW && show_done && BLANK_CYCLES != 0;
  assign advance    = state == IDLE || (state == SHOW && show_done && BLANK_CYCLES == 0) ||
                      (state == BLANK && blank_done);
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    idx_n   = digit_idx;
    val_n   = val;
    tick_n  = 1'b0;
    if (to_blank) begin
      state_n = BLANK;
      cnt_n   = '0;
    end else if (advance) begin
      state_n = any_en ? SHOW : IDLE;
      cnt_n   = '0;
      if (any_en) begin
        idx_n  = nidx;
        val_n  = digits[nidx*DATA_W +: DATA_W];
        tick_n = wrapped || state == IDLE;
      end
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      digit_idx  <= '0;
      val        <= BLANK_CODE;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      digit_idx  <= idx_n;
      val        <= val_n;
      frame_tick <= tick_n;
    end
`ifdef MULTIPLEX_N_DIM_EN
  logic [3:0] bright_q;
  logic [31:0] on_len;
  always_ff @(posedge clk or posedge reset)
    if (reset) bright_q <= 4'hF;
    else if (advance && any_en) bright_q <= bright;
  assign on_len = ((32'(bright_q) + 32'd1) * 32'(DWELL_CYCLES)) >> 4;
  assign lit = 32'(cnt) < ((on_len == 32'd0) ? 32'd1 : on_len);
`else
  assign lit = 1'b1;
`endif
  assign d = (state == SHOW && lit) ? ~(NUM_DIGITS'(1) << digit_idx) : '1;
  assign s = (state == SHOW && lit) ? val : BLANK_CODE;
endmodule

// File: tb/tb_multiplex_n.sv
// tb_multiplex_n: randomized scan checks of multiplex_n (blanking and no-blanking builds) against a countdown model.
module tb_multiplex_n;
  localparam int N = 4;
  localparam int DW = 4;
  localparam int BLK [2] = '{2, 0};
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [15:0] digits = 16'h4321;
  logic [3:0] en_mask = 4'b0;
  logic [3:0] bright = 4'hF;
  logic [3:0] d_a, s_a, d_b, s_b;
  logic [1:0] ix_a, ix_b;
  logic ft_a, ft_b;
  logic [10:0] obs [2];
  int n_vec = 0, n_err = 0;
  int m_mode [2], m_left [2], m_idx [2], m_br [2];
  logic [3:0] m_val [2];
  bit m_tick [2];
  always #5 clk = ~clk;
  multiplex_n #(.NUM_DIGITS(N), .DATA_W(4), .DWELL_CYCLES(DW), .BLANK_CYCLES(2)) u_a (
    .clk(clk), .reset(reset), .digits(digits), .en_mask(en_mask),
`ifdef MULTIPLEX_N_DIM_EN
    .bright(bright),
`endif
    .d(d_a), .s(s_a), .digit_idx(ix_a), .frame_tick(ft_a));
  multiplex_n #(.NUM_DIGITS(N), .DATA_W(4), .DWELL_CYCLES(DW), .BLANK_CYCLES(0)) u_b (
    .clk(clk), .reset(reset), .digits(digits), .en_mask(en_mask),
`ifdef MULTIPLEX_N_DIM_EN
    .bright(bright),
`endif
    .d(d_b), .s(s_b), .digit_idx(ix_b), .frame_tick(ft_b));
  assign obs[0] = {d_a, s_a, ix_a, ft_a};
  assign obs[1] = {d_b, s_b, ix_b, ft_b};
  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_left[k] = 0; m_idx[k] = 0; m_tick[k] = 0; m_br[k] = 15; m_val[k] = 4'hF;
    end
  endtask
  task automatic choose(input int k, input bit from_idle);
    int base, nx;
    nx = -1;
    if (en_mask == 4'b0) begin
      m_mode[k] = 0;
      return;
    end
    base = from_idle ? N - 1 : m_idx[k];
    for (int j = 1; j <= N; j++) if (nx < 0 && en_mask[(base + j) % N]) nx = (base + j) % N;
    m_tick[k] = from_idle || nx <= m_idx[k];
    m_idx[k]  = nx;
    m_val[k]  = digits[nx*4 +: 4];
    m_br[k]   = int'(bright);
    m_mode[k] = 1;
    m_left[k] = DW;
  endtask
  task automatic model_step(input int k);
    m_tick[k] = 0;
    case (m_mode[k])
      0: if (en_mask != 4'b0) choose(k, 1'b1);
      1: begin
        m_left[k]--;
        if (m_left[k] == 0) begin
          if (BLK[k] > 0) begin m_mode[k] = 2; m_left[k] = BLK[k]; end
          else choose(k, 1'b0);
        end
      end
      default: begin
        m_left[k]--;
        if (m_left[k] == 0) choose(k, 1'b0);
      end
    endcase
  endtask
  function automatic logic [10:0] expv(input int k);
    logic [3:0] dd, ss;
    bit on;
    int lim;
    dd = 4'hF; ss = 4'hF;
    on = m_mode[k] == 1;
    lim = DW;
`ifdef MULTIPLEX_N_DIM_EN
    lim = ((m_br[k] + 1) * DW) / 16;
    if (lim < 1) lim = 1;
`endif
    if (on && (DW - m_left[k]) < lim) begin
      dd[m_idx[k]] = 1'b0;
      ss = m_val[k];
    end
    return {dd, ss, 2'(m_idx[k]), m_tick[k]};
  endfunction
  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    en_mask = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (obs[k] !== 11'h7F8) begin
        n_err++;
        $display("FAIL reset inst=%0d got=%h expected=%h", k, obs[k], 11'h7F8);
      end
    end
    en_mask = 4'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask
  task automatic test_default_timing();
    digits = 16'h4321;
    en_mask = 4'b1111;
    for (int c = 0; c < 60; c++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        n_vec++;
        if (obs[k] !== expv(k)) begin
          n_err++;
          $display("FAIL default inst=%0d cyc=%0d got=%h expected=%h", k, c, obs[k], expv(k));
        end
      end
    end
  endtask
  task automatic test_skipped();
    en_mask = 4'b1010;
    for (int c = 0; c < 40; c++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        n_vec++;
        if (obs[k] !== expv(k)) begin
          n_err++;
          $display("FAIL skipped inst=%0d cyc=%0d got=%h expected=%h", k, c, obs[k], expv(k));
        end
      end
    end
  endtask
  task automatic test_single_digit();
    en_mask = 4'b0001;
    for (int c = 0; c < 30; c++) begin
      digits = 16'($urandom);
      tick();
      for (int k = 0; k < 2; k++) begin
        n_vec++;
        if (obs[k] !== expv(k)) begin
          n_err++;
          $display("FAIL single inst=%0d cyc=%0d got=%h expected=%h", k, c, obs[k], expv(k));
        end
      end
    end
  endtask
  task automatic test_mask_transitions();
    en_mask = 4'b1111;
    for (int c = 0; c < 40; c++) begin
      if (c == 7) en_mask = 4'b0000;
      if (c == 24) en_mask = 4'b0100;
      tick();
      for (int k = 0; k < 2; k++) begin
        n_vec++;
        if (obs[k] !== expv(k)) begin
          n_err++;
          $display("FAIL masktrans inst=%0d cyc=%0d got=%h expected=%h", k, c, obs[k], expv(k));
        end
      end
    end
  endtask
  task automatic test_async_reset();
    en_mask = 4'b1111;
    repeat (3) tick();
    #2;
    reset = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (obs[k][10:3] !== 8'hFF) begin
        n_err++;
        $display("FAIL async_reset inst=%0d got=%h expected=ff", k, obs[k][10:3]);
      end
    end
    model_reset();
    en_mask = 4'b0110;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 25; c++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        n_vec++;
        if (obs[k] !== expv(k)) begin
          n_err++;
          $display("FAIL after_reset inst=%0d cyc=%0d got=%h expected=%h", k, c, obs[k], expv(k));
        end
      end
    end
  endtask
  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      digits = 16'($urandom);
      if ($urandom_range(0, 15) == 0) en_mask = 4'($urandom);
`ifdef MULTIPLEX_N_DIM_EN
      bright = 4'($urandom);
`endif
      tick();
      for (int k = 0; k < 2; k++) begin
        n_vec++;
        if (obs[k] !== expv(k)) begin
          n_err++;
          $display("FAIL random inst=%0d cyc=%0d got=%h expected=%h", k, c, obs[k], expv(k));
        end
      end
    end
  endtask
`ifdef MULTIPLEX_N_DIM_EN
  task automatic test_dim();
    en_mask = 4'b1111;
    for (int c = 0; c < 80; c++) begin
      bright = (c < 40) ? 4'd3 : 4'd15;
      tick();
      for (int k = 0; k < 2; k++) begin
        n_vec++;
        if (obs[k] !== expv(k)) begin
          n_err++;
          $display("FAIL dim inst=%0d cyc=%0d got=%h expected=%h", k, c, obs[k], expv(k));
        end
      end
    end
    bright = 4'hF;
  endtask
`endif
  initial begin
    model_reset();
    test_reset();
    test_default_timing();
    test_skipped();
    test_single_digit();
    test_mask_transitions();
    test_async_reset();
`ifdef MULTIPLEX_N_DIM_EN
    test_dim();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/multiplex_n.md
Name: multiplex_n

Overview:
- Parametrised time-division multiplexer for common-anode multi-digit seven-segment displays; successor to the 2-digit multiplexer.
- Cycles through up to NUM_DIGITS digit values and drives one active-low digit enable at a time.
- Presents the selected DATA_W-bit code to the downstream seven-segment decoder.
- Adds a per-digit enable mask, a blanking (anti-ghosting) interval between digits, a frame tick, and optional brightness dimming.

Parameters:
- NUM_DIGITS, 4, number of digits multiplexed (2..8).
- DATA_W, 4, width of each digit code.
- DWELL_CYCLES, 50000, clk cycles each digit is shown (>=1).
- BLANK_CYCLES, 500, clk cycles all digits are off between digits (0 = no blanking).
- BLANK_CODE, all-ones, value on s whenever no digit is active.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- digits  in  NUM_DIGITS*DATA_W  packed digit codes; digit i = digits[i*DATA_W +: DATA_W].
- en_mask  in  NUM_DIGITS  1 = digit i takes part in the scan.
- d  out  NUM_DIGITS  active-low digit enables; at most one bit low at any time.
- s  out  DATA_W  code of the active digit, BLANK_CODE otherwise.
- digit_idx  out  $clog2(NUM_DIGITS)  index of the current/last shown digit.
- frame_tick  out  1  one-cycle pulse at the start of each scan frame.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: state=IDLE, counter=0, digit_idx=0, d=all ones, s=BLANK_CODE, frame_tick=0.
- Outputs: decoded from registered state, latched value and counter only; no combinational path from digits or en_mask to d or s.
- States:
  - IDLE: all digits off.
  - SHOW: d[digit_idx]=0, s=latched value.
  - BLANK: all digits off, s=BLANK_CODE.
- IDLE: if en_mask==0, stay in IDLE. Otherwise, on the next clk go to SHOW with digit_idx = lowest set bit of en_mask.
- SHOW entry (any path): latch digits[idx] and clear the counter. Digit changes during a dwell are not shown until the next entry.
- SHOW duration: exactly DWELL_CYCLES cycles (counter 0..DWELL_CYCLES-1). Then:
  - go to BLANK if BLANK_CYCLES>0;
  - otherwise go straight to SHOW of the next digit.
- BLANK duration: exactly BLANK_CYCLES cycles, counter cleared on entry. Then go to SHOW of the next digit.
- Next digit: lowest enabled index strictly greater than digit_idx, otherwise wrap to the lowest enabled index.
  - en_mask is sampled on the cycle the next digit is chosen.
  - A digit whose mask bit drops mid-dwell still completes that dwell.
- If en_mask==0 when the next digit is chosen, go to IDLE (digit_idx held).
- frame_tick pulses on the cycle SHOW is entered when the new index <= previous index, and on the first SHOW after IDLE. With a single enabled digit, it pulses on every entry.
- Reset mid-operation: all digits off immediately (asynchronous), back to IDLE.
- Counter width: $clog2(max(DWELL_CYCLES,BLANK_CYCLES)+1); no overflow possible.

Optional Feature:
- Macro: MULTIPLEX_N_DIM_EN.
- Defined:
  - Adds input bright [3:0].
  - Within SHOW, the digit enable is low only while counter < ((bright+1)*DWELL_CYCLES)>>4, using a minimum of 1 cycle.
  - For the remainder of the dwell, d is all ones and s=BLANK_CODE.
  - bright is sampled at SHOW entry.
  - bright=15 gives full duty.
  - Dwell/blank timing and frame_tick are unchanged.
- Undefined: the bright port is absent and the digit is on for the full dwell.

Decomposition:
- Package multiplex_pkg: state enum {IDLE, SHOW, BLANK} (2-bit), and function next_enabled(mask, idx) returning the wrap-around next enabled index.
- One sub-module, mux_next_digit: combinational round-robin finder wrapping next_enabled. It outputs next_idx, a wrapped flag (used for frame_tick) and an any_en flag.

Test Plan:
- Default timing: NUM_DIGITS=4, DWELL=4, BLANK=2, en_mask=4'b1111, digits=16'h4321.
  - Expect s sequence 1,2,3,4 with each value held 4 cycles.
  - d equals 1110, 1101, 1011, 0111 for each respective dwell, with 2 cycles of d=1111, s=F between digits.
  - frame_tick every 24 cycles, on entry to digit 0.
- Skipped digits: en_mask=4'b1010 -> only digits 1 and 3 are shown, alternating; frame_tick on each entry to digit 1.
- No blanking: BLANK=0, en_mask=4'b0001 -> d=1110 continuously, frame_tick every 4 cycles, s follows digits[3:0] only at dwell boundaries.
- Mask transitions:
  - en_mask goes 0 mid-scan -> current dwell completes, then IDLE with d=1111.
  - Setting en_mask=4'b0100 -> SHOW digit 2 on the next cycle, with frame_tick.
- Asynchronous reset: assert reset mid-SHOW between clock edges -> d=1111, s=F before the next edge. After release, first SHOW is on the lowest enabled digit.
- Dimming (MULTIPLEX_N_DIM_EN, DWELL=16): bright=3 -> each digit low for 4 of 16 dwell cycles; bright=15 -> 16 of 16.
